// File: rtl/anim_pkg.sv
// Shared types for the sprite animation blocks: palette codes, ghost channel states, code field widths.
// Pure declarations; no latency or flow control.
// Consumers import anim_pkg::* and size their output buses from CODE_W.
package anim_pkg;

    localparam int CODE_W        = 4;
    localparam int FRAME_FIELD_W = 2;

    typedef enum logic [1:0] {
        PAL_NORMAL = 2'b00,
        PAL_BLUE   = 2'b01,
        PAL_WHITE  = 2'b10
    } palette_t;

    typedef enum logic {
        NORMAL = 1'b0,
        SCARED = 1'b1
    } ghost_state_t;

endpackage

// File: rtl/anim_prescaler.sv
// Divides the enabled clock into one tick every PERIOD enabled cycles; restart resynchronises the phase.
// Latency: tick is combinational from the count register, so it is high during the last cycle of each period.
// No backpressure: enable=0 freezes the count, and restart wins over a coincident wrap.
module anim_prescaler #(
    parameter int PERIOD = 5_000_000,
    parameter int CNT_W  = 23
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || restart || tick) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ghost_anim_seq.sv
// Multi-channel ghost animation sequencer: lockstep frame counter, shared fright timer, per-ghost palette FSMs.
// Latency: ghost_code and fright_active are registered, one cycle after the input pulse or tick.
// No backpressure: enable=0 pauses the frames and the timer; fright_start and eaten act on every cycle.
module ghost_anim_seq
    import anim_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int NUM_FRAMES   = 2,
    parameter int PERIOD       = 5_000_000,
    parameter int CNT_W        = 23,
    parameter int FRIGHT_TICKS = 40,
    parameter int FLASH_TICKS  = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     restart,
    input  logic                     fright_start,
    input  logic [NUM_CH-1:0]        eaten,
    output logic [NUM_CH*CODE_W-1:0] ghost_code,
    output logic                     fright_active
);

    localparam int TIMER_W = $clog2(FRIGHT_TICKS + 1);
    localparam logic [TIMER_W-1:0]       T_LOAD  = TIMER_W'(FRIGHT_TICKS);
    localparam logic [TIMER_W-1:0]       T_FLASH = TIMER_W'(FLASH_TICKS);
    localparam logic [TIMER_W-1:0]       T_ONE   = TIMER_W'(1);
    localparam logic [FRAME_FIELD_W-1:0] F_LAST  = FRAME_FIELD_W'(NUM_FRAMES - 1);

    logic                     tick;
    logic [FRAME_FIELD_W-1:0] frame_q, frame_nxt;
    logic [TIMER_W-1:0]       timer_q, timer_nxt;
    logic                     expire;
    wire  [NUM_CH*CODE_W-1:0] code_nxt;

    anim_prescaler #(
        .PERIOD (PERIOD),
        .CNT_W  (CNT_W)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .restart (restart),
        .tick    (tick)
    );

    always_comb begin
        frame_nxt = frame_q;
        if (restart) begin
            frame_nxt = '0;
        end else if (tick) begin
            frame_nxt = (frame_q == F_LAST) ? '0 : frame_q + 1'b1;
        end
    end

    // A load always beats a coincident tick, so a reload never expires the fright.
    always_comb begin
        timer_nxt = timer_q;
        expire    = 1'b0;
        if (fright_start) begin
            timer_nxt = T_LOAD;
        end else if (tick && timer_q != '0) begin
            timer_nxt = timer_q - 1'b1;
            expire    = (timer_q == T_ONE);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ghost_state_t state_q, state_nxt;
        palette_t     pal_nxt;

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= NORMAL;
            end else begin
                state_q <= state_nxt;
            end
        end

        always_comb begin
            state_nxt = state_q;
            case (state_q)
                NORMAL:  if (fright_start && !eaten[i]) state_nxt = SCARED;
                SCARED:  if (eaten[i] || expire)        state_nxt = NORMAL;
                default: state_nxt = NORMAL;
            endcase
        end

        // Palette is derived from next-state values so the registered code lines up with the update edge.
        always_comb begin
            pal_nxt = PAL_NORMAL;
            if (state_nxt == SCARED) begin
                if (timer_nxt > T_FLASH || timer_nxt[0]) begin
                    pal_nxt = PAL_BLUE;
                end else begin
                    pal_nxt = PAL_WHITE;
                end
            end
        end

        assign code_nxt[i*CODE_W +: CODE_W] = {pal_nxt, frame_nxt};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_q       <= '0;
            timer_q       <= '0;
            ghost_code    <= '0;
            fright_active <= 1'b0;
        end else begin
            frame_q       <= frame_nxt;
            timer_q       <= timer_nxt;
            ghost_code    <= code_nxt;
            fright_active <= (timer_nxt != '0);
        end
    end

endmodule

// File: tb/tb_ghost_anim_seq.sv
// Directed bench for ghost_anim_seq: stimulus pushes hand-derived expectations, a monitor pops and compares each cycle.
module tb_ghost_anim_seq;

    localparam int NUM_CH = 4;

    localparam logic [1:0] NRM = 2'b00;
    localparam logic [1:0] BLU = 2'b01;
    localparam logic [1:0] WHT = 2'b10;

    logic                clk;
    logic                reset;
    logic                enable;
    logic                restart;
    logic                fright_start;
    logic [NUM_CH-1:0]   eaten;
    logic [NUM_CH*4-1:0] ghost_code;
    logic                fright_active;

    typedef struct packed {
        logic [15:0] code;
        logic        fa;
    } exp_t;

    exp_t  expq[$];
    string tagq[$];
    int    checks = 0;
    int    errors = 0;

    ghost_anim_seq #(
        .NUM_CH       (4),
        .NUM_FRAMES   (3),
        .PERIOD       (4),
        .CNT_W        (2),
        .FRIGHT_TICKS (6),
        .FLASH_TICKS  (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .restart       (restart),
        .fright_start  (fright_start),
        .eaten         (eaten),
        .ghost_code    (ghost_code),
        .fright_active (fright_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mk_code(input logic [1:0] frm, input logic [7:0] pal);
        logic [15:0] c;
        c = '0;
        for (int i = 0; i < 4; i++) begin
            c[i*4 +: 4] = {pal[i*2 +: 2], frm};
        end
        return c;
    endfunction

    // Palette vector {ch3,ch2,ch1,ch0}: scared channels (mask bit set) show p, others NORMAL.
    function automatic logic [7:0] pal_mask(input logic [3:0] mask, input logic [1:0] p);
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            v[i*2 +: 2] = mask[i] ? p : NRM;
        end
        return v;
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the following rising edge.
    task automatic cyc(input string tag, input logic rst, input logic en, input logic rs,
                       input logic fs, input logic [3:0] eat,
                       input logic [1:0] frm, input logic [7:0] pal, input logic fa);
        @(negedge clk);
        reset        = rst;
        enable       = en;
        restart      = rs;
        fright_start = fs;
        eaten        = eat;
        expq.push_back('{code: mk_code(frm, pal), fa: fa});
        tagq.push_back(tag);
    endtask

    initial begin : monitor
        exp_t  e;
        string t;
        forever begin
            @(posedge clk);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                t = tagq.pop_front();
                checks++;
                if (ghost_code !== e.code || fright_active !== e.fa) begin
                    errors++;
                    $display("FAIL %s t=%0t: got code=%h fa=%b, need code=%h fa=%b",
                             t, $time, ghost_code, fright_active, e.code, e.fa);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [1:0] frm;
        logic [1:0] p;
        logic [3:0] mask;

        reset = 1'b1; enable = 1'b0; restart = 1'b0; fright_start = 1'b0; eaten = '0;

        repeat (2) cyc("reset", 1, 0, 0, 0, 4'b0, 2'd0, 8'h00, 0);

        // Free run: frame after enabled edge n is (n/4) mod 3.
        for (int n = 1; n <= 14; n++) begin
            frm = 2'((n / 4) % 3);
            cyc("freerun", 0, 1, 0, 0, 4'b0, frm, 8'h00, 0);
        end

        // Pause with prescaler at 2: two enabled cycles remain before the next frame.
        repeat (10) cyc("pause_hold", 0, 0, 0, 0, 4'b0, 2'd0, 8'h00, 0);
        cyc("resume_1", 0, 1, 0, 0, 4'b0, 2'd0, 8'h00, 0);
        cyc("resume_2", 0, 1, 0, 0, 4'b0, 2'd1, 8'h00, 0);

        // Fright: ticks on k=3,7,...,23 take the timer 6->0.
        for (int k = 0; k <= 23; k++) begin
            frm = 2'((1 + (k + 1) / 4) % 3);
            p   = (k < 15) ? BLU : (k < 19) ? WHT : (k < 23) ? BLU : NRM;
            cyc("fright", 0, 1, 0, (k == 0), 4'b0, frm, pal_mask(4'b1111, p), (k < 23));
        end

        // Eaten priority, then a reload on the tick where the timer is 1 (k=23).
        for (int k = 0; k <= 39; k++) begin
            frm  = 2'((1 + (k + 1) / 4) % 3);
            p    = (k < 15) ? BLU : (k < 19) ? WHT : (k < 39) ? BLU : WHT;
            mask = (k == 0) ? 4'b1011 : (k < 23) ? 4'b1001 : 4'b1111;
            cyc((k < 23) ? "eaten" : "reload", 0, 1, 0, (k == 0 || k == 23),
                (k == 0) ? 4'b0100 : (k == 1) ? 4'b0010 : 4'b0000,
                frm, pal_mask(mask, p), 1'b1);
        end

        // Timer runs out (2->0), then restart lands on the tick at frame 1 (k=11).
        for (int k = 0; k <= 15; k++) begin
            frm = (k < 3) ? 2'd2 : (k < 7) ? 2'd0 : (k < 11) ? 2'd1 : (k < 15) ? 2'd0 : 2'd1;
            p   = (k < 3) ? WHT : (k < 7) ? BLU : NRM;
            cyc("restart", 0, 1, (k == 11), 0, 4'b0, frm, pal_mask(4'b1111, p), (k < 7));
        end

        // Reset in the middle of a fright clears everything including the prescaler phase.
        cyc("pre_reset", 0, 1, 0, 1, 4'b0, 2'd1, pal_mask(4'b1111, BLU), 1);
        cyc("mid_reset", 1, 1, 0, 0, 4'b0, 2'd0, 8'h00, 0);
        repeat (3) cyc("post_reset", 0, 1, 0, 0, 4'b0, 2'd0, 8'h00, 0);
        cyc("post_reset_tick", 0, 1, 0, 0, 4'b0, 2'd1, 8'h00, 0);

        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked entries, need 0", expq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
